fsm_counter_ctrl: RTL and testbench

FSM_COUNTER_CTRL -- requirements
Module: fsm_counter_ctrl

---
 rtl/fsm_counter_pkg.sv | 18 +
 rtl/fsm_counter_ctrl_cnt_core.sv | 37 +++
 rtl/fsm_counter_ctrl.sv | 124 ++++++++++++
 tb/tb_fsm_counter_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_counter_pkg.sv
// Shared types and helpers for the counter-controller FSM.
// State encodings are fixed so they can be read directly off a debug bus.
package fsm_counter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned LoopsW = 8;

  function automatic logic [LoopsW-1:0] sat_inc(input logic [LoopsW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fsm_counter_ctrl_cnt_core.sv
// Count register with synchronous clear, enable and terminal-count compare.
// The core never advances past target-1, so the count cannot wrap.
module cnt_core #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] target,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  logic [CNT_W-1:0] count_q, count_d;

  assign terminal = (count_q == target - 1'b1);
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !terminal) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fsm_counter_ctrl.sv
// Run/pause/abort controller around a terminal counter, with optional auto-reload.
// Every output is a register or a decode of the state register.
module fsm_counter_ctrl
  import fsm_counter_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned RELOAD_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  input  logic [CNT_W-1:0] i_num_cnt,
  input  logic             i_reload,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic             o_idle,
  output logic             o_running,
  output logic             o_paused,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cnt,
  output logic [7:0]       o_loops
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic               reload_q, reload_d;
  logic               err_q, err_d;
  logic [LoopsW-1:0]  loops_q, loops_d;
  logic               cnt_clear, cnt_en, terminal;
  logic               start_ok, start_bad;

  assign start_ok  = i_run && (i_num_cnt != '0);
  assign start_bad = i_run && (i_num_cnt == '0);

  cnt_core #(
    .CNT_W (CNT_W)
  ) u_cnt_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .target   (num_q),
    .count    (o_cnt),
    .terminal (terminal)
  );

  // Priority inside RUN: abort, then pause, then terminal count.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    reload_d  = reload_q;
    err_d     = 1'b0;
    loops_d   = loops_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_clear = 1'b1;
        if (start_ok) begin
          state_d  = StRun;
          num_d    = i_num_cnt;
          reload_d = (RELOAD_EN != 0) && i_reload;
        end else if (start_bad) begin
          err_d = 1'b1;
        end
      end
      StRun: begin
        if (i_abort) begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
        end else if (i_pause) begin
          state_d = StPause;
        end else if (terminal) begin
          state_d   = StDone;
          cnt_clear = 1'b1;
          loops_d   = sat_inc(loops_q);
        end else begin
          cnt_en = 1'b1;
        end
      end
      StPause: begin
        if (i_abort) begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
        end else if (!i_pause) begin
          state_d = StRun;
        end
      end
      StDone: begin
        cnt_clear = 1'b1;
        state_d   = (reload_q && !i_abort) ? StRun : StIdle;
      end
      default: begin
        state_d   = StIdle;
        cnt_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      num_q    <= '0;
      reload_q <= 1'b0;
      err_q    <= 1'b0;
      loops_q  <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      reload_q <= reload_d;
      err_q    <= err_d;
      loops_q  <= loops_d;
    end
  end

  assign o_idle    = (state_q == StIdle);
  assign o_running = (state_q == StRun);
  assign o_paused  = (state_q == StPause);
  assign o_done    = (state_q == StDone);
  assign o_err     = err_q;
  assign o_loops   = loops_q;

endmodule

// File: tb/tb_fsm_counter_ctrl.sv
// Directed bench for fsm_counter_ctrl (CNT_W=8, RELOAD_EN=1).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_fsm_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_run = 1'b0;
  logic [7:0] i_num_cnt = 8'd0;
  logic       i_reload = 1'b0;
  logic       i_pause = 1'b0;
  logic       i_abort = 1'b0;
  logic       o_idle, o_running, o_paused, o_done, o_err;
  logic [7:0] o_cnt;
  logic [7:0] o_loops;

  int vec = 0;
  int errs = 0;
  int exp_loops = 0;

  fsm_counter_ctrl #(
    .CNT_W     (8),
    .RELOAD_EN (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_run     (i_run),
    .i_num_cnt (i_num_cnt),
    .i_reload  (i_reload),
    .i_pause   (i_pause),
    .i_abort   (i_abort),
    .o_idle    (o_idle),
    .o_running (o_running),
    .o_paused  (o_paused),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_cnt     (o_cnt),
    .o_loops   (o_loops)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    vec++; if ({o_idle, o_running, o_paused, o_done, o_err} !== 5'b10000) begin
      errs++; $display("FAIL reset_flags: got %b want 10000",
                       {o_idle, o_running, o_paused, o_done, o_err}); end
    vec++; if (o_cnt !== 8'd0) begin
      errs++; $display("FAIL reset_cnt: got %0d want 0", o_cnt); end
    vec++; if (o_loops !== 8'd0) begin
      errs++; $display("FAIL reset_loops: got %0d want 0", o_loops); end
    step(); step();
    reset = 1'b0;
    step();
    vec++; if ({o_idle, o_running, o_cnt} !== {1'b1, 1'b0, 8'd0}) begin
      errs++; $display("FAIL post_reset_idle: got idle=%b run=%b cnt=%0d want 1 0 0",
                       o_idle, o_running, o_cnt); end
  endtask

  task automatic test_zero_then_one();
    i_run = 1'b1; i_num_cnt = 8'd0;
    step();
    i_run = 1'b0;
    vec++; if ({o_idle, o_err} !== 2'b11) begin
      errs++; $display("FAIL zero_start_err: got idle=%b err=%b want 1 1", o_idle, o_err); end
    step();
    vec++; if ({o_idle, o_err, o_loops} !== {2'b10, 8'd0}) begin
      errs++; $display("FAIL zero_err_pulse: got idle=%b err=%b loops=%0d want 1 0 0",
                       o_idle, o_err, o_loops); end
    i_run = 1'b1; i_num_cnt = 8'd1;
    step();
    i_run = 1'b0;
    vec++; if ({o_running, o_cnt} !== {1'b1, 8'd0}) begin
      errs++; $display("FAIL n1_run: got run=%b cnt=%0d want 1 0", o_running, o_cnt); end
    step();
    exp_loops++;
    vec++; if ({o_done, o_running, o_loops} !== {2'b10, 8'(exp_loops)}) begin
      errs++; $display("FAIL n1_done: got done=%b run=%b loops=%0d want 1 0 %0d",
                       o_done, o_running, o_loops, exp_loops); end
    step();
    vec++; if ({o_idle, o_done} !== 2'b10) begin
      errs++; $display("FAIL n1_idle: got idle=%b done=%b want 1 0", o_idle, o_done); end
  endtask

  task automatic test_basic_oneshot();
    i_run = 1'b1; i_num_cnt = 8'd5; i_reload = 1'b0;
    step();
    i_run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vec++; if ({o_running, o_cnt} !== {1'b1, 8'(i)}) begin
        errs++; $display("FAIL basic_run[%0d]: got run=%b cnt=%0d want 1 %0d",
                         i, o_running, o_cnt, i); end
      step();
    end
    exp_loops++;
    vec++; if ({o_done, o_cnt, o_loops} !== {1'b1, 8'd0, 8'(exp_loops)}) begin
      errs++; $display("FAIL basic_done: got done=%b cnt=%0d loops=%0d want 1 0 %0d",
                       o_done, o_cnt, o_loops, exp_loops); end
    step();
    vec++; if ({o_idle, o_done} !== 2'b10) begin
      errs++; $display("FAIL basic_idle: got idle=%b done=%b want 1 0", o_idle, o_done); end
  endtask

  task automatic test_pause();
    i_run = 1'b1; i_num_cnt = 8'd6;
    step();
    i_run = 1'b0;
    step(); step();
    vec++; if ({o_running, o_cnt} !== {1'b1, 8'd2}) begin
      errs++; $display("FAIL pause_pre: got run=%b cnt=%0d want 1 2", o_running, o_cnt); end
    i_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++; if ({o_paused, o_running, o_cnt} !== {2'b10, 8'd2}) begin
        errs++; $display("FAIL pause_hold[%0d]: got paused=%b run=%b cnt=%0d want 1 0 2",
                         i, o_paused, o_running, o_cnt); end
    end
    i_pause = 1'b0;
    step();
    for (int i = 2; i < 6; i++) begin
      vec++; if ({o_running, o_done, o_cnt} !== {2'b10, 8'(i)}) begin
        errs++; $display("FAIL pause_resume[%0d]: got run=%b done=%b cnt=%0d want 1 0 %0d",
                         i, o_running, o_done, o_cnt, i); end
      step();
    end
    exp_loops++;
    vec++; if ({o_done, o_loops} !== {1'b1, 8'(exp_loops)}) begin
      errs++; $display("FAIL pause_done: got done=%b loops=%0d want 1 %0d",
                       o_done, o_loops, exp_loops); end
    step();
    vec++; if ({o_idle, o_done} !== 2'b10) begin
      errs++; $display("FAIL pause_idle: got idle=%b done=%b want 1 0", o_idle, o_done); end
  endtask

  task automatic test_pause_beats_terminal();
    i_run = 1'b1; i_num_cnt = 8'd2;
    step();
    i_run = 1'b0;
    step();
    i_pause = 1'b1;
    step();
    i_pause = 1'b0;
    vec++; if ({o_paused, o_done, o_cnt} !== {2'b10, 8'd1}) begin
      errs++; $display("FAIL pause_tc: got paused=%b done=%b cnt=%0d want 1 0 1",
                       o_paused, o_done, o_cnt); end
    step();
    vec++; if ({o_running, o_cnt} !== {1'b1, 8'd1}) begin
      errs++; $display("FAIL pause_tc_resume: got run=%b cnt=%0d want 1 1", o_running, o_cnt); end
    step();
    exp_loops++;
    vec++; if ({o_done, o_loops} !== {1'b1, 8'(exp_loops)}) begin
      errs++; $display("FAIL pause_tc_done: got done=%b loops=%0d want 1 %0d",
                       o_done, o_loops, exp_loops); end
    step();
  endtask

  task automatic test_reload_abort();
    i_run = 1'b1; i_num_cnt = 8'd4; i_reload = 1'b1;
    step();
    i_run = 1'b0; i_reload = 1'b0; i_num_cnt = 8'd9;
    for (int it = 1; it <= 3; it++) begin
      for (int i = 0; i < 4; i++) begin
        vec++; if ({o_running, o_cnt} !== {1'b1, 8'(i)}) begin
          errs++; $display("FAIL reload_run[%0d.%0d]: got run=%b cnt=%0d want 1 %0d",
                           it, i, o_running, o_cnt, i); end
        step();
      end
      exp_loops++;
      vec++; if ({o_done, o_loops} !== {1'b1, 8'(exp_loops)}) begin
        errs++; $display("FAIL reload_done[%0d]: got done=%b loops=%0d want 1 %0d",
                         it, o_done, o_loops, exp_loops); end
      step();
    end
    vec++; if ({o_running, o_cnt} !== {1'b1, 8'd0}) begin
      errs++; $display("FAIL reload_restart: got run=%b cnt=%0d want 1 0", o_running, o_cnt); end
    step(); step();
    i_abort = 1'b1; i_pause = 1'b1;
    step();
    i_abort = 1'b0; i_pause = 1'b0;
    vec++; if ({o_idle, o_done, o_cnt, o_loops} !== {2'b10, 8'd0, 8'(exp_loops)}) begin
      errs++; $display("FAIL abort_run: got idle=%b done=%b cnt=%0d loops=%0d want 1 0 0 %0d",
                       o_idle, o_done, o_cnt, o_loops, exp_loops); end
    step(); step();
    vec++; if ({o_idle, o_done} !== 2'b10) begin
      errs++; $display("FAIL abort_no_done: got idle=%b done=%b want 1 0", o_idle, o_done); end
    // Abort during DONE of a reload run must land in IDLE.
    i_run = 1'b1; i_num_cnt = 8'd1; i_reload = 1'b1;
    step();
    i_run = 1'b0; i_reload = 1'b0;
    step();
    exp_loops++;
    vec++; if ({o_done, o_loops} !== {1'b1, 8'(exp_loops)}) begin
      errs++; $display("FAIL abort_done_pre: got done=%b loops=%0d want 1 %0d",
                       o_done, o_loops, exp_loops); end
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    vec++; if ({o_idle, o_running} !== 2'b10) begin
      errs++; $display("FAIL abort_in_done: got idle=%b run=%b want 1 0", o_idle, o_running); end
  endtask

  task automatic test_long_no_wrap();
    int  n_run;
    int  max_cnt;
    bit  got_done;
    n_run = 0; max_cnt = 0; got_done = 1'b0;
    i_run = 1'b1; i_num_cnt = 8'd255; i_reload = 1'b0;
    step();
    i_num_cnt = 8'd3;
    for (int k = 0; k < 300; k++) begin
      if (o_done) begin
        got_done = 1'b1;
        break;
      end
      if (o_running) begin
        n_run++;
        if (int'(o_cnt) > max_cnt) max_cnt = int'(o_cnt);
      end
      step();
    end
    i_run = 1'b0;
    vec++; if (got_done !== 1'b1) begin
      errs++; $display("FAIL long_done: got %b want 1 (no done within 300 cycles)", got_done); end
    vec++; if (n_run !== 255) begin
      errs++; $display("FAIL long_run_cycles: got %0d want 255", n_run); end
    vec++; if (max_cnt !== 254) begin
      errs++; $display("FAIL long_peak: got %0d want 254", max_cnt); end
    exp_loops++;
    vec++; if (o_loops !== 8'(exp_loops)) begin
      errs++; $display("FAIL long_loops: got %0d want %0d", o_loops, exp_loops); end
    step();
    vec++; if ({o_idle, o_cnt} !== {1'b1, 8'd0}) begin
      errs++; $display("FAIL long_idle: got idle=%b cnt=%0d want 1 0", o_idle, o_cnt); end
  endtask

  task automatic test_async_reset();
    i_run = 1'b1; i_num_cnt = 8'd10;
    step();
    i_run = 1'b0;
    step(); step(); step();
    vec++; if ({o_running, o_cnt} !== {1'b1, 8'd3}) begin
      errs++; $display("FAIL areset_pre: got run=%b cnt=%0d want 1 3", o_running, o_cnt); end
    #2;
    reset = 1'b1;
    #1;
    exp_loops = 0;
    vec++; if ({o_idle, o_running, o_paused, o_done, o_err} !== 5'b10000) begin
      errs++; $display("FAIL areset_flags: got %b want 10000",
                       {o_idle, o_running, o_paused, o_done, o_err}); end
    vec++; if ({o_cnt, o_loops} !== {8'd0, 8'd0}) begin
      errs++; $display("FAIL areset_regs: got cnt=%0d loops=%0d want 0 0", o_cnt, o_loops); end
    step();
    vec++; if ({o_idle, o_done} !== 2'b10) begin
      errs++; $display("FAIL areset_hold: got idle=%b done=%b want 1 0", o_idle, o_done); end
    reset = 1'b0;
    step();
    vec++; if ({o_idle, o_done, o_loops} !== {2'b10, 8'd0}) begin
      errs++; $display("FAIL areset_release: got idle=%b done=%b loops=%0d want 1 0 0",
                       o_idle, o_done, o_loops); end
  endtask

  initial begin
    test_reset();
    test_zero_then_one();
    test_basic_oneshot();
    test_pause();
    test_pause_beats_terminal();
    test_reload_abort();
    test_long_no_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
